// File: rtl/bp_pkg.sv
// Shared definitions for the perceptron branch predictor and its update path.
// Provides default field widths, the training threshold, a ceil-log2 helper
// and the layout of the in-flight prediction record {addr, hist, sum, taken}.
package bp_pkg;

  localparam int unsigned BP_ADDR_W = 64;
  localparam int unsigned BP_HIST_W = 64;
  localparam int unsigned BP_SUM_W  = 16;
  localparam int unsigned BP_THETA  = 2 * BP_HIST_W + 14;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Packed record width for a given set of field widths.
  function automatic int unsigned rec_width(input int unsigned addr_w,
                                            input int unsigned hist_w,
                                            input int unsigned sum_w);
    return addr_w + hist_w + sum_w + 1;
  endfunction

  localparam int unsigned BP_REC_W = rec_width(BP_ADDR_W, BP_HIST_W, BP_SUM_W);

  // Record layout at the default widths, MSB first.
  typedef struct packed {
    logic [BP_ADDR_W-1:0]        addr;
    logic [BP_HIST_W-1:0]        hist;
    logic signed [BP_SUM_W-1:0]  sum;
    logic                        taken;
  } bp_rec_t;

endpackage

// File: rtl/bp_sync_fifo.sv
// Generic synchronous FIFO with flush.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous clear of pointers/occupancy (wins over push/pop)
//   push, wdata  : write request and data (ignored when full)
//   pop, rdata   : read request (ignored when empty); rdata shows head entry
//   occupancy    : entries held; full/empty derived from it
module bp_sync_fifo
  import bp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic [clog2(DEPTH):0]   occupancy,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic             push_ok, pop_ok;

  assign full    = (occ_q == (PTR_W+1)'(DEPTH));
  assign empty   = (occ_q == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      occ_d = occ_q + (PTR_W+1)'(1);
      else if (pop_ok && !push_ok) occ_d = occ_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order in-flight branch queue behind the perceptron predictor.
// Captures prediction records, pairs each arriving outcome with the oldest
// record, and emits a registered update command carrying the mispredict and
// train decisions. Also keeps saturating resolve / mispredict counters.
//   pred_*    : prediction record input (valid/ready)
//   res_*     : outcome input for oldest in-flight branch (valid/ready)
//   upd_*     : registered update command (valid/ready), 1-cycle latency
//   occupancy : entries currently held
//   stat_*    : saturating statistics, not affected by flush
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W = BP_ADDR_W,
  parameter int unsigned HIST_W = BP_HIST_W,
  parameter int unsigned SUM_W  = BP_SUM_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned THETA  = BP_THETA,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    pred_valid,
  output logic                    pred_ready,
  input  logic [ADDR_W-1:0]       pred_addr,
  input  logic                    pred_taken,
  input  logic [SUM_W-1:0]        pred_sum,
  input  logic [HIST_W-1:0]       pred_hist,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic                    res_taken,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [ADDR_W-1:0]       upd_addr,
  output logic [HIST_W-1:0]       upd_hist,
  output logic                    upd_taken,
  output logic                    upd_mispredict,
  output logic                    upd_train,
  output logic [clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]        stat_branches,
  output logic [CNT_W-1:0]        stat_mispred
);

  localparam int unsigned REC_W = rec_width(ADDR_W, HIST_W, SUM_W);
  localparam logic signed [SUM_W-1:0] THETA_S = SUM_W'(THETA);

  logic [REC_W-1:0]         wr_rec, rd_rec;
  logic                     fifo_full, fifo_empty;
  logic                     push, res_fire, out_free;

  logic [ADDR_W-1:0]        rec_addr;
  logic [HIST_W-1:0]        rec_hist;
  logic signed [SUM_W-1:0]  rec_sum;
  logic                     rec_taken;
  logic                     mispredict, train;

  logic                     upd_valid_q, upd_valid_d;
  logic [ADDR_W-1:0]        upd_addr_q, upd_addr_d;
  logic [HIST_W-1:0]        upd_hist_q, upd_hist_d;
  logic                     upd_taken_q, upd_taken_d;
  logic                     upd_mispredict_q, upd_mispredict_d;
  logic                     upd_train_q, upd_train_d;
  logic [CNT_W-1:0]         stat_branches_q, stat_branches_d;
  logic [CNT_W-1:0]         stat_mispred_q, stat_mispred_d;

  assign wr_rec = {pred_addr, pred_hist, pred_sum, pred_taken};
  assign {rec_addr, rec_hist, rec_sum, rec_taken} = rd_rec;

  // Readiness uses registered occupancy only: a record pushed this cycle is
  // never resolvable in the same cycle, and a pop never frees a full slot early.
  assign out_free   = !upd_valid_q || upd_ready;
  assign pred_ready = rst_n && !flush && !fifo_full;
  assign res_ready  = rst_n && !flush && !fifo_empty && out_free;
  assign push       = pred_valid && pred_ready;
  assign res_fire   = res_valid && res_ready;

  bp_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .wdata     (wr_rec),
    .pop       (res_fire),
    .rdata     (rd_rec),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Train when wrong, or when the sum lies strictly inside (-THETA, THETA).
  assign mispredict = rec_taken ^ res_taken;
  assign train      = mispredict || ((rec_sum > -THETA_S) && (rec_sum < THETA_S));

  always_comb begin
    upd_valid_d      = upd_valid_q;
    upd_addr_d       = upd_addr_q;
    upd_hist_d       = upd_hist_q;
    upd_taken_d      = upd_taken_q;
    upd_mispredict_d = upd_mispredict_q;
    upd_train_d      = upd_train_q;
    if (flush) begin
      upd_valid_d = 1'b0;
    end else if (res_fire) begin
      upd_valid_d      = 1'b1;
      upd_addr_d       = rec_addr;
      upd_hist_d       = rec_hist;
      upd_taken_d      = res_taken;
      upd_mispredict_d = mispredict;
      upd_train_d      = train;
    end else if (upd_ready) begin
      upd_valid_d = 1'b0;
    end
  end

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (res_fire && (stat_branches_q != '1))
      stat_branches_d = stat_branches_q + CNT_W'(1);
    if (res_fire && mispredict && (stat_mispred_q != '1))
      stat_mispred_d = stat_mispred_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_q      <= 1'b0;
      upd_addr_q       <= '0;
      upd_hist_q       <= '0;
      upd_taken_q      <= 1'b0;
      upd_mispredict_q <= 1'b0;
      upd_train_q      <= 1'b0;
      stat_branches_q  <= '0;
      stat_mispred_q   <= '0;
    end else begin
      upd_valid_q      <= upd_valid_d;
      upd_addr_q       <= upd_addr_d;
      upd_hist_q       <= upd_hist_d;
      upd_taken_q      <= upd_taken_d;
      upd_mispredict_q <= upd_mispredict_d;
      upd_train_q      <= upd_train_d;
      stat_branches_q  <= stat_branches_d;
      stat_mispred_q   <= stat_mispred_d;
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_addr       = upd_addr_q;
  assign upd_hist       = upd_hist_q;
  assign upd_taken      = upd_taken_q;
  assign upd_mispredict = upd_mispredict_q;
  assign upd_train      = upd_train_q;
  assign stat_branches  = stat_branches_q;
  assign stat_mispred   = stat_mispred_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;
  localparam int THETA = 142;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        pred_valid, pred_ready, pred_taken;
  logic [63:0] pred_addr, pred_hist;
  logic [15:0] pred_sum;
  logic        res_valid, res_ready, res_taken;
  logic        upd_valid, upd_ready, upd_taken, upd_mispredict, upd_train;
  logic [63:0] upd_addr, upd_hist;
  logic [3:0]  occupancy;
  logic [31:0] stat_branches, stat_mispred;

  // Second instance with 4-bit counters for saturation.
  logic        d2_pv, d2_pr, d2_rv, d2_rr, d2_uv, d2_ut, d2_um, d2_utr;
  logic [63:0] d2_ua, d2_uh;
  logic [3:0]  d2_occ, d2_sb, d2_sm;

  always #5 clk = ~clk;

  branch_resolve_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_addr(pred_addr),
    .pred_taken(pred_taken), .pred_sum(pred_sum), .pred_hist(pred_hist),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
    .upd_hist(upd_hist), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .upd_train(upd_train), .occupancy(occupancy),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  branch_resolve_queue #(.CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .pred_valid(d2_pv), .pred_ready(d2_pr), .pred_addr(64'h55),
    .pred_taken(1'b1), .pred_sum(16'sd300), .pred_hist(64'hAA),
    .res_valid(d2_rv), .res_ready(d2_rr), .res_taken(1'b0),
    .upd_valid(d2_uv), .upd_ready(1'b1), .upd_addr(d2_ua),
    .upd_hist(d2_uh), .upd_taken(d2_ut), .upd_mispredict(d2_um),
    .upd_train(d2_utr), .occupancy(d2_occ),
    .stat_branches(d2_sb), .stat_mispred(d2_sm)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit run_model = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [63:0]        addr;
    logic [63:0]        hist;
    logic signed [15:0] sum;
    logic               taken;
  } rec_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] hist;
    logic        taken;
    logic        mis;
    logic        train;
    int          cyc;
  } exp_t;

  rec_t        mq[$];
  exp_t        exp_q[$];
  bit          pend = 0;
  int unsigned m_br = 0, m_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: in-order queue plus the spec's readiness and train rules.
  always @(negedge clk) begin
    if (rst_n && run_model) begin
      bit   e_pr, e_rr;
      rec_t r;
      exp_t e;
      int   s;
      e_pr = !flush && (mq.size() < DEPTH);
      e_rr = !flush && (mq.size() > 0) && (!pend || upd_ready);
      chk("pred_ready", pred_ready, e_pr);
      chk("res_ready", res_ready, e_rr);
      chk("occupancy", occupancy, mq.size());
      chk("stat_branches", stat_branches, m_br);
      chk("stat_mispred", stat_mispred, m_mis);
      if (flush) begin
        mq.delete();
        pend = 0;
      end else begin
        if (res_valid && e_rr) begin
          r = mq.pop_front();
          s = int'(r.sum);
          e.addr  = r.addr;
          e.hist  = r.hist;
          e.taken = res_taken;
          e.mis   = r.taken ^ res_taken;
          e.train = e.mis || (s > -THETA && s < THETA);
          e.cyc   = cyc;
          exp_q.push_back(e);
          if (m_br != 32'hFFFF_FFFF) m_br++;
          if (e.mis && m_mis != 32'hFFFF_FFFF) m_mis++;
          pend = 1;
        end else if (upd_ready) begin
          pend = 0;
        end
        if (pred_valid && e_pr) begin
          r.addr = pred_addr; r.hist = pred_hist;
          r.sum = pred_sum;   r.taken = pred_taken;
          mq.push_back(r);
        end
      end
    end
  end

  // Monitor: entries become visible one cycle after the resolve that made them.
  always @(negedge clk) begin
    if (rst_n && run_model) begin
      bit   avail;
      exp_t e;
      avail = (exp_q.size() > 0) && (exp_q[0].cyc < cyc);
      chk("upd_valid", upd_valid, avail);
      if (upd_valid && avail) begin
        e = exp_q[0];
        chk("upd_fields", {upd_addr, upd_hist, upd_taken, upd_mispredict, upd_train},
            {e.addr, e.hist, e.taken, e.mis, e.train});
        if (upd_ready) void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
    end
  end

  always @(negedge clk) begin
    if (rst_n && d2_uv)
      chk("d2_upd", {d2_ua, d2_uh, d2_ut, d2_um, d2_utr}, {64'h55, 64'hAA, 1'b0, 1'b1, 1'b1});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pred(input logic t, input logic [15:0] s);
    pred_addr  = {$urandom, $urandom};
    pred_hist  = {$urandom, $urandom};
    pred_taken = t;
    pred_sum   = s;
  endtask

  task automatic rand_pred();
    logic [15:0] s;
    case ($urandom_range(0, 6))
      0: s = 16'd142;
      1: s = -16'sd142;
      2: s = 16'd141;
      3: s = -16'sd141;
      4: s = 16'(int'($urandom_range(0, 20)) - 10);
      default: s = 16'($urandom);
    endcase
    set_pred(($urandom_range(0, 7) == 0) ? ($signed(s) <= 0) : ($signed(s) > 0), s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; flush = 0; pred_valid = 1; res_valid = 0; res_taken = 0; upd_ready = 0;
    d2_pv = 0; d2_rv = 0;
    set_pred(1'b1, 16'd1);
    repeat (3) @(negedge clk);
    chk("rst_pred_ready", pred_ready, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_stats", {stat_branches, stat_mispred}, 0);
    chk("rst_d2", {d2_pr, d2_occ, d2_sb, d2_sm}, 0);
    pred_valid = 0;
    step();
    rst_n = 1; run_model = 1;
    step();

    // In-order resolve with train decisions near the threshold.
    upd_ready = 1;
    pred_valid = 1;
    set_pred(1'b1, 16'd200);   step();
    set_pred(1'b0, -16'sd5);   step();
    set_pred(1'b0, -16'sd142); step();
    pred_valid = 0;
    res_valid = 1;
    res_taken = 1; step();
    res_taken = 0; step();
    step();
    res_valid = 0;
    step(); step();

    // Mispredict.
    pred_valid = 1; set_pred(1'b1, 16'd300); step();
    pred_valid = 0; res_valid = 1; res_taken = 0; step();
    res_valid = 0; step();
    chk("mispred_stat", stat_mispred, 1);

    // Fill, then backpressure on the output register.
    upd_ready = 0;
    pred_valid = 1;
    for (int i = 0; i < 9; i++) begin rand_pred(); step(); end
    pred_valid = 0;
    res_valid = 1; res_taken = $urandom_range(0, 1); step();
    chk("occ_after_first_resolve", occupancy, 7);
    for (int i = 0; i < 4; i++) begin res_taken = $urandom_range(0, 1); step(); end
    upd_ready = 1;
    for (int i = 0; i < 10; i++) begin res_taken = $urandom_range(0, 1); step(); end
    res_valid = 0; step();

    // Steady push+pop at occupancy 4.
    pred_valid = 1;
    for (int i = 0; i < 4; i++) begin rand_pred(); step(); end
    res_valid = 1;
    for (int i = 0; i < 20; i++) begin rand_pred(); res_taken = $urandom_range(0, 1); step(); end
    chk("occ_steady", occupancy, 4);
    pred_valid = 0;
    for (int i = 0; i < 5; i++) begin res_taken = $urandom_range(0, 1); step(); end
    res_valid = 0; step();

    // Flush at occupancy 5 with a pending update.
    upd_ready = 0;
    pred_valid = 1;
    for (int i = 0; i < 6; i++) begin rand_pred(); step(); end
    pred_valid = 0; res_valid = 1; step();
    res_valid = 0; step();
    flush = 1; pred_valid = 1; res_valid = 1; step();
    flush = 0; pred_valid = 0; res_valid = 0;
    @(negedge clk);
    chk("flush_occ", occupancy, 0);
    chk("flush_upd_valid", upd_valid, 0);
    step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      pred_valid = ($urandom_range(0, 3) != 0);
      rand_pred();
      res_valid  = ($urandom_range(0, 2) != 0);
      res_taken  = $urandom_range(0, 1);
      upd_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 63) == 0);
      step();
    end
    pred_valid = 0; res_valid = 0; flush = 0; upd_ready = 1;
    step(); step();

    // Counter saturation on the 4-bit instance.
    for (int i = 0; i < 20; i++) begin
      d2_pv = 1;
      @(negedge clk); chk("d2_pred_ready", d2_pr, 1);
      step(); d2_pv = 0; d2_rv = 1;
      @(negedge clk); chk("d2_res_ready", d2_rr, 1);
      step(); d2_rv = 0;
    end
    step();
    chk("d2_stat_branches_sat", d2_sb, 15);
    chk("d2_stat_mispred_sat", d2_sm, 15);
    chk("d2_occupancy", d2_occ, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
